rob_multi_commit: RTL and testbench
===================================

# rob_multi_commit

Parametrised reorder buffer and commit unit for the out-of-order core. It takes over the writeback/commit role from the single-port ROB. It accepts one allocation per cycle from decode and `NUM_WB` writeback results per cycle from execute. It retires up to `COMMIT_WIDTH` in-order instructions per cycle to the architectural register, predicate and store paths. Exceptions are precise: on an excepting head it flushes all entries and halts.

## Interface
- `ROB_ADDR_SIZE`, 4: log2 of entry count; DEPTH = 2^ROB_ADDR_SIZE.
- `DEST_ADDR_SIZE`, 5: destination address width.
- `INS_TYPE_SIZE`, 2: instruction type width; 00 none, 01 store, 10 reg write, 11 pred write.
- `EXCEPTION_ID_SIZE`, 4: exception code width; 0 = no exception.
- `DATA_WIDTH`, 32: result data width.
- `NUM_WB`, 2: writeback ports, 1..4.
- `COMMIT_WIDTH`, 2: commit slots, 1..4, must not exceed DEPTH.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `alloc_valid`  in  1  allocate entry at tail.
- `alloc_dest_addr`  in  DEST_ADDR_SIZE  destination of new entry.
- `alloc_ins_type`  in  INS_TYPE_SIZE  type of new entry.
- `alloc_exception`  in  EXCEPTION_ID_SIZE  decode-time exception; nonzero marks entry finished+excepting.
- `alloc_ready`  out  1  allocation accepted this cycle.
- `alloc_id`  out  ROB_ADDR_SIZE  tail pointer; the id given to the allocating instruction.
- `wb_valid`  in  NUM_WB  per-port writeback strobe.
- `wb_rob_id`  in  NUM_WB*ROB_ADDR_SIZE  packed target ids, port 0 in LSBs.
- `wb_data`  in  NUM_WB*DATA_WIDTH  packed results.
- `wb_exception`  in  NUM_WB*EXCEPTION_ID_SIZE  packed exception codes.
- `commit_valid`  out  COMMIT_WIDTH  slot i retires this cycle; slot 0 = head.
- `commit_ins_type`  out  COMMIT_WIDTH*INS_TYPE_SIZE  packed types.
- `commit_dest_addr`  out  COMMIT_WIDTH*DEST_ADDR_SIZE  packed destinations.
- `commit_data`  out  COMMIT_WIDTH*DATA_WIDTH  packed results.
- `count`  out  ROB_ADDR_SIZE+1  occupied entries.
- `empty`  out  1  count == 0.
- `flush`  out  1  one-cycle pulse on exception.
- `halt`  out  1  sticky until reset.
- `exception_code`  out  EXCEPTION_ID_SIZE  latched code of the excepting instruction.
- `exception_rob_id`  out  ROB_ADDR_SIZE  latched id of the excepting instruction.

## Operation
- Per-entry state: valid, finished, exception code, dest, type, data. Head and tail are ROB_ADDR_SIZE pointers that wrap modulo DEPTH. Count is explicit, so full (DEPTH) and empty (0) are distinguishable.
- FSM states are RUN and HALTED.
- **Allocation:** `alloc_ready = (count != DEPTH) & RUN`. When `alloc_valid & alloc_ready`:
  - write the entry at tail with valid=1;
  - set finished = (alloc_exception != 0);
  - advance tail.
  - `alloc_valid` while not ready is ignored.
- **Writeback:**
  - A port writes data and exception into entry `wb_rob_id` and sets finished, only if that entry is valid and the state is RUN. Otherwise it is ignored.
  - If two ports target the same id in one cycle, the higher port index wins.
- **Commit:**
  - Slot i, at entry head+i, commits iff the state is RUN and entries head..head+i are all valid, finished and exception-free.
  - A commit clears the entry's valid bit and advances head by the number of slots committed.
  - Type 00 commits with `commit_valid` high; the consumer ignores it.
- **Exception:** when the head entry is valid, finished and has a nonzero exception, in RUN:
  - no slot commits that cycle;
  - at the edge: latch `exception_code` and `exception_rob_id` = head;
  - clear all valid bits; head = tail = 0, count = 0;
  - `flush` = 1 for one cycle, `halt` = 1;
  - go to HALTED.
- An excepting entry at slot i>0 blocks slots ≥ i. Earlier slots commit, and the exception is taken once that entry reaches head.
- **HALTED:** terminal until reset. `alloc_ready` = 0, all `commit_valid` = 0, writebacks ignored.
- **Count:** next count = count + alloc_accepted − number of committed slots. Allocation and commit may occur in the same cycle, including when full: a commit in cycle t frees a slot for cycle t+1, never cycle t.

## Timing
- Commit outputs are combinational from registered state only; there is no bypass from `wb_*` or `alloc_*`.
- Earliest commit of an entry is the cycle after its writeback edge, which is itself at least one cycle after allocation.
- `alloc_ready`, `alloc_id`, `count` and `empty` are derived from registered state.
- `flush`, `halt` and `exception_*` are registers and change at the edge that takes the exception.
- **Reset** (any cycle, including mid-exception): all entries invalid, head = tail = count = 0, state RUN. Output values:
  - `alloc_ready` = 1, `empty` = 1, `alloc_id` = 0;
  - `commit_valid` = 0, `flush` = 0, `halt` = 0;
  - `exception_code` = 0, `exception_rob_id` = 0.

## Test plan
- **Basic:** allocate ids 0,1,2; write back 2, then 0, then 1 on port 0 in successive cycles. Required: no commit until id 0 finishes; id 0 commits alone; ids 1 and 2 commit together the cycle after id 1's writeback; `empty` = 1 afterward.
- **Full / wrap:** allocate 16 entries (default parameters). Required: `count` = 16 and `alloc_ready` = 0. Then finish ids 0,1 and hold `alloc_valid`. Required: ids 0,1 commit; `alloc_ready` = 1 the next cycle; the new entry gets `alloc_id` = 0 (wrap).
- **Dual writeback:** both ports write ids 3 and 4 in the same cycle. Required: both are finished next cycle. Then both ports target id 5 with data A (port 0) and B (port 1). Required: committed data = B.
- **Exception:** ids 0..3 allocated; id 2 written with exception 0x5; ids 0,1,3 finished. Required: ids 0,1 commit; next cycle `flush` pulses and `halt` = 1; `exception_code` = 5, `exception_rob_id` = 2; id 3 never commits; `alloc_ready` = 0.
- **Decode exception:** allocate with `alloc_exception` = 0x3 into an empty ROB. Required: exception is taken 1 cycle later with no writeback needed.
- **Reset while HALTED:** assert `reset` one cycle while HALTED. Required: all outputs return to reset values; a fresh allocation gets `alloc_id` = 0.

Source files
------------

// File: rtl/rob_multi_commit.sv
// Reorder buffer with NUM_WB writeback ports and up to COMMIT_WIDTH
// in-order retirements per cycle; an excepting head flushes and halts.
module rob_multi_commit #(
    parameter int ROB_ADDR_SIZE     = 4,
    parameter int DEST_ADDR_SIZE    = 5,
    parameter int INS_TYPE_SIZE     = 2,
    parameter int EXCEPTION_ID_SIZE = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_WB            = 2,
    parameter int COMMIT_WIDTH      = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  alloc_valid,
    input  logic [DEST_ADDR_SIZE-1:0]             alloc_dest_addr,
    input  logic [INS_TYPE_SIZE-1:0]              alloc_ins_type,
    input  logic [EXCEPTION_ID_SIZE-1:0]          alloc_exception,
    output logic                                  alloc_ready,
    output logic [ROB_ADDR_SIZE-1:0]              alloc_id,
    input  logic [NUM_WB-1:0]                     wb_valid,
    input  logic [NUM_WB*ROB_ADDR_SIZE-1:0]       wb_rob_id,
    input  logic [NUM_WB*DATA_WIDTH-1:0]          wb_data,
    input  logic [NUM_WB*EXCEPTION_ID_SIZE-1:0]   wb_exception,
    output logic [COMMIT_WIDTH-1:0]               commit_valid,
    output logic [COMMIT_WIDTH*INS_TYPE_SIZE-1:0] commit_ins_type,
    output logic [COMMIT_WIDTH*DEST_ADDR_SIZE-1:0] commit_dest_addr,
    output logic [COMMIT_WIDTH*DATA_WIDTH-1:0]    commit_data,
    output logic [ROB_ADDR_SIZE:0]                count,
    output logic                                  empty,
    output logic                                  flush,
    output logic                                  halt,
    output logic [EXCEPTION_ID_SIZE-1:0]          exception_code,
    output logic [ROB_ADDR_SIZE-1:0]              exception_rob_id
);
    localparam int DEPTH = 1 << ROB_ADDR_SIZE;
    localparam logic [ROB_ADDR_SIZE:0] FULL = (ROB_ADDR_SIZE+1)'(DEPTH);
    localparam logic [ROB_ADDR_SIZE:0] ONE = (ROB_ADDR_SIZE+1)'(1);

    typedef enum logic { RUN, HALTED } state_t;
    state_t state_q, state_d;

    logic [DEPTH-1:0]             valid_q, fin_q, valid_d, fin_d;
    logic [EXCEPTION_ID_SIZE-1:0] exc_q  [DEPTH];
    logic [DEST_ADDR_SIZE-1:0]    dest_q [DEPTH];
    logic [INS_TYPE_SIZE-1:0]     type_q [DEPTH];
    logic [DATA_WIDTH-1:0]        data_q [DEPTH];
    logic [ROB_ADDR_SIZE-1:0]     head_q, tail_q;
    logic [ROB_ADDR_SIZE:0]       count_q, n_commit;
    logic [ROB_ADDR_SIZE-1:0]     slot_idx [COMMIT_WIDTH];
    logic [ROB_ADDR_SIZE-1:0]     wb_id [NUM_WB];
    logic [COMMIT_WIDTH-1:0]      commit_mask;
    logic                         running, alloc_fire, take_exc, blocked;

    for (genvar p = 0; p < NUM_WB; p++) begin : g_wb
        assign wb_id[p] = wb_rob_id[p*ROB_ADDR_SIZE +: ROB_ADDR_SIZE];
    end

    assign running     = (state_q == RUN);
    assign alloc_ready = running && (count_q != FULL);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_id    = tail_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);

    assign take_exc = running && valid_q[head_q] && fin_q[head_q]
                   && (exc_q[head_q] != '0);

    // Commit stops at the first slot that is not ready, so retirement stays in order.
    always_comb begin
        commit_mask = '0;
        n_commit    = '0;
        blocked     = !running;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            slot_idx[i] = head_q + ROB_ADDR_SIZE'(i);
            if (!blocked && valid_q[slot_idx[i]] && fin_q[slot_idx[i]]
                && (exc_q[slot_idx[i]] == '0)) begin
                commit_mask[i] = 1'b1;
                n_commit       = n_commit + ONE;
            end else begin
                blocked = 1'b1;
            end
        end
    end

    assign commit_valid = commit_mask;

    for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_slot
        assign commit_ins_type[g*INS_TYPE_SIZE +: INS_TYPE_SIZE] =
            type_q[slot_idx[g]];
        assign commit_dest_addr[g*DEST_ADDR_SIZE +: DEST_ADDR_SIZE] =
            dest_q[slot_idx[g]];
        assign commit_data[g*DATA_WIDTH +: DATA_WIDTH] =
            data_q[slot_idx[g]];
    end

    always_comb begin
        valid_d = valid_q;
        fin_d   = fin_q;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && valid_q[wb_id[p]]) begin
                fin_d[wb_id[p]] = 1'b1;
            end
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_mask[i]) begin
                valid_d[slot_idx[i]] = 1'b0;
            end
        end
        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            fin_d[tail_q]   = (alloc_exception != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (take_exc) state_d = HALTED;
            HALTED: state_d = HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            valid_q          <= '0;
            fin_q            <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            flush            <= 1'b0;
            halt             <= 1'b0;
            exception_code   <= '0;
            exception_rob_id <= '0;
        end else begin
            state_q <= state_d;
            flush   <= take_exc;
            if (take_exc) begin
                valid_q          <= '0;
                head_q           <= '0;
                tail_q           <= '0;
                count_q          <= '0;
                halt             <= 1'b1;
                exception_code   <= exc_q[head_q];
                exception_rob_id <= head_q;
            end else if (running) begin
                valid_q <= valid_d;
                fin_q   <= fin_d;
                head_q  <= head_q + n_commit[ROB_ADDR_SIZE-1:0];
                if (alloc_fire) begin
                    tail_q <= tail_q + ROB_ADDR_SIZE'(1);
                end
                count_q <= count_q + (ROB_ADDR_SIZE+1)'(alloc_fire) - n_commit;
            end
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    // Later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            dest_q[tail_q] <= alloc_dest_addr;
            type_q[tail_q] <= alloc_ins_type;
            exc_q[tail_q]  <= alloc_exception;
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (running && wb_valid[p] && valid_q[wb_id[p]]) begin
                data_q[wb_id[p]] <= wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                exc_q[wb_id[p]]  <=
                    wb_exception[p*EXCEPTION_ID_SIZE +: EXCEPTION_ID_SIZE];
            end
        end
    end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: vector table, directed corner cases and
// random traffic against a queue-based model of the reorder buffer.
module tb_rob_multi_commit;
    localparam int RA = 4, DA = 5, IT = 2, EX = 4, DW = 32;
    localparam int NW = 2, CW = 2, DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    logic alloc_valid;
    logic [DA-1:0] alloc_dest_addr;
    logic [IT-1:0] alloc_ins_type;
    logic [EX-1:0] alloc_exception;
    logic alloc_ready;
    logic [RA-1:0] alloc_id;
    logic [NW-1:0] wb_valid;
    logic [NW*RA-1:0] wb_rob_id;
    logic [NW*DW-1:0] wb_data;
    logic [NW*EX-1:0] wb_exception;
    logic [CW-1:0] commit_valid;
    logic [CW*IT-1:0] commit_ins_type;
    logic [CW*DA-1:0] commit_dest_addr;
    logic [CW*DW-1:0] commit_data;
    logic [RA:0] count;
    logic empty, flush, halt;
    logic [EX-1:0] exception_code;
    logic [RA-1:0] exception_rob_id;

    always #5 clk = ~clk;

    rob_multi_commit #(
        .ROB_ADDR_SIZE(RA), .DEST_ADDR_SIZE(DA), .INS_TYPE_SIZE(IT),
        .EXCEPTION_ID_SIZE(EX), .DATA_WIDTH(DW), .NUM_WB(NW),
        .COMMIT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_dest_addr(alloc_dest_addr),
        .alloc_ins_type(alloc_ins_type), .alloc_exception(alloc_exception),
        .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
        .wb_exception(wb_exception),
        .commit_valid(commit_valid), .commit_ins_type(commit_ins_type),
        .commit_dest_addr(commit_dest_addr), .commit_data(commit_data),
        .count(count), .empty(empty), .flush(flush), .halt(halt),
        .exception_code(exception_code),
        .exception_rob_id(exception_rob_id)
    );

    typedef struct {
        int id; bit fin; int exc; int dest; int typ; bit [31:0] data;
    } ent_t;

    ent_t rq[$];
    int tail_id, m_code, m_xid;
    bit halted, m_flush;
    int checks = 0, errors = 0;

    typedef struct {
        bit av; bit wv; int wid; bit [31:0] wd;
        bit [1:0] ecv; int ecnt; bit [31:0] ed0;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        alloc_valid = 0; alloc_dest_addr = '0; alloc_ins_type = '0;
        alloc_exception = '0; wb_valid = '0; wb_rob_id = '0;
        wb_data = '0; wb_exception = '0;
    endtask

    task automatic set_wb(int p, int id, bit [31:0] d, int e);
        wb_valid[p] = 1'b1;
        wb_rob_id[p*RA +: RA] = RA'(id);
        wb_data[p*DW +: DW] = d;
        wb_exception[p*EX +: EX] = EX'(e);
    endtask

    task automatic model_clear();
        rq.delete(); tail_id = 0; halted = 0;
        m_flush = 0; m_code = 0; m_xid = 0;
    endtask

    task automatic do_reset();
        reset = 1; clr_in();
        @(posedge clk); #1;
        reset = 0;
        model_clear();
    endtask

    // Compare all outputs to the model, then advance one clock.
    task automatic tick();
        int n; bit take; bit rdy; bit [CW-1:0] cv; ent_t e;
        n = 0; take = 0; cv = '0;
        if (!halted) begin
            for (int i = 0; i < CW && i < rq.size(); i++) begin
                if (rq[i].fin && rq[i].exc == 0) n++;
                else break;
            end
            take = rq.size() > 0 && rq[0].fin && rq[0].exc != 0;
        end
        for (int i = 0; i < n; i++) cv[i] = 1'b1;
        rdy = !halted && rq.size() < DEPTH;
        chk("commit_valid", commit_valid, cv);
        for (int i = 0; i < n; i++) begin
            chk("c_dest", commit_dest_addr[i*DA +: DA], rq[i].dest);
            chk("c_type", commit_ins_type[i*IT +: IT], rq[i].typ);
            chk("c_data", commit_data[i*DW +: DW], rq[i].data);
        end
        chk("count", count, rq.size());
        chk("empty", empty, rq.size() == 0);
        chk("alloc_ready", alloc_ready, rdy);
        chk("alloc_id", alloc_id, tail_id);
        chk("flush", flush, m_flush);
        chk("halt", halt, halted);
        chk("exc_code", exception_code, m_code);
        chk("exc_id", exception_rob_id, m_xid);
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else if (take) begin
            m_code = rq[0].exc; m_xid = rq[0].id;
            rq.delete(); tail_id = 0; halted = 1; m_flush = 1;
        end else begin
            m_flush = 0;
            if (!halted) begin
                for (int p = 0; p < NW; p++) begin
                    if (!wb_valid[p]) continue;
                    foreach (rq[k]) begin
                        if (rq[k].id == int'(wb_rob_id[p*RA +: RA])) begin
                            rq[k].fin = 1;
                            rq[k].data = wb_data[p*DW +: DW];
                            rq[k].exc = int'(wb_exception[p*EX +: EX]);
                        end
                    end
                end
                repeat (n) void'(rq.pop_front());
                if (alloc_valid && rdy) begin
                    e.id = tail_id; e.exc = int'(alloc_exception);
                    e.fin = alloc_exception != 0;
                    e.dest = int'(alloc_dest_addr);
                    e.typ = int'(alloc_ins_type); e.data = '0;
                    rq.push_back(e);
                    tail_id = (tail_id + 1) % DEPTH;
                end
            end
        end
        #1;
    endtask

    initial begin
        int hcnt;
        tbl[0] = '{1, 0, 0, 32'h0,  2'b00, 0, 32'h0};
        tbl[1] = '{1, 0, 0, 32'h0,  2'b00, 1, 32'h0};
        tbl[2] = '{1, 0, 0, 32'h0,  2'b00, 2, 32'h0};
        tbl[3] = '{0, 1, 2, 32'h22, 2'b00, 3, 32'h0};
        tbl[4] = '{0, 1, 0, 32'h10, 2'b00, 3, 32'h0};
        tbl[5] = '{0, 1, 1, 32'h11, 2'b01, 3, 32'h10};
        tbl[6] = '{0, 0, 0, 32'h0,  2'b11, 2, 32'h11};
        tbl[7] = '{0, 0, 0, 32'h0,  2'b00, 0, 32'h0};

        do_reset();

        // basic in-order commit
        for (int r = 0; r < 8; r++) begin
            clr_in();
            alloc_valid = tbl[r].av;
            alloc_dest_addr = DA'(r + 1);
            alloc_ins_type = 2'b10;
            if (tbl[r].wv) set_wb(0, tbl[r].wid, tbl[r].wd, 0);
            chk("tbl_cv", commit_valid, tbl[r].ecv);
            chk("tbl_count", count, tbl[r].ecnt);
            if (tbl[r].ecv[0]) chk("tbl_data0", commit_data[DW-1:0], tbl[r].ed0);
            tick();
        end
        chk("basic_empty", empty, 1);

        // full and wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            clr_in(); alloc_valid = 1; alloc_dest_addr = DA'(i); tick();
        end
        clr_in();
        chk("full_count", count, 16);
        chk("full_ready", alloc_ready, 0);
        set_wb(0, 0, 32'h100, 0); set_wb(1, 1, 32'h101, 0);
        tick();
        clr_in(); alloc_valid = 1;
        chk("full_cv", commit_valid, 2'b11);
        chk("full_ready2", alloc_ready, 0);
        tick();
        chk("wrap_ready", alloc_ready, 1);
        chk("wrap_id", alloc_id, 0);
        chk("wrap_count", count, 14);
        tick();
        chk("wrap_id2", alloc_id, 1);
        chk("wrap_count2", count, 15);
        clr_in();

        // dual writeback, same-id conflict
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clr_in(); alloc_valid = 1; alloc_ins_type = 2'b11; tick();
        end
        clr_in(); set_wb(0, 3, 32'h33, 0); set_wb(1, 4, 32'h44, 0); tick();
        clr_in(); set_wb(0, 5, 32'hAAAA, 0); set_wb(1, 5, 32'hBBBB, 0); tick();
        clr_in(); set_wb(0, 0, 32'h1, 0); set_wb(1, 1, 32'h2, 0);
        chk("dual_cv0", commit_valid, 2'b00); tick();
        clr_in(); set_wb(0, 2, 32'h3, 0);
        chk("dual_cv1", commit_valid, 2'b11); tick();
        clr_in();
        chk("dual_cv2", commit_valid, 2'b11);
        chk("dual_d3", commit_data[DW +: DW], 32'h33); tick();
        chk("dual_cv3", commit_valid, 2'b11);
        chk("dual_d4", commit_data[DW-1:0], 32'h44);
        chk("dual_win", commit_data[DW +: DW], 32'hBBBB); tick();
        chk("dual_empty", empty, 1);

        // writeback exception on id 2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clr_in(); alloc_valid = 1; tick();
        end
        clr_in(); set_wb(0, 0, 32'h5, 0); set_wb(1, 1, 32'h6, 0); tick();
        clr_in(); set_wb(0, 2, 32'h7, 5); set_wb(1, 3, 32'h8, 0);
        chk("exc_cv01", commit_valid, 2'b11); tick();
        clr_in();
        chk("exc_cv_blk", commit_valid, 2'b00);
        chk("exc_pre_flush", flush, 0); tick();
        chk("exc_flush", flush, 1);
        chk("exc_halt", halt, 1);
        chk("exc_code5", exception_code, 5);
        chk("exc_id2", exception_rob_id, 2);
        chk("exc_ready", alloc_ready, 0);
        alloc_valid = 1; set_wb(0, 3, 32'h9, 0); tick();
        chk("exc_flush_off", flush, 0);
        chk("exc_halt_hold", halt, 1);
        chk("exc_no_commit", commit_valid, 2'b00);
        chk("exc_count", count, 0);

        // reset while halted
        clr_in(); reset = 1; tick(); reset = 0;
        chk("rst_ready", alloc_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_id", alloc_id, 0);
        chk("rst_halt", halt, 0);
        chk("rst_code", exception_code, 0);
        chk("rst_xid", exception_rob_id, 0);

        // decode-time exception
        alloc_valid = 1; alloc_exception = 3; tick();
        clr_in();
        chk("dec_cv", commit_valid, 2'b00);
        chk("dec_pre", flush, 0); tick();
        chk("dec_flush", flush, 1);
        chk("dec_halt", halt, 1);
        chk("dec_code", exception_code, 3);
        chk("dec_id", exception_rob_id, 0);

        // random traffic
        do_reset();
        hcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            clr_in();
            hcnt = halted ? hcnt + 1 : 0;
            reset = (hcnt > 3) || ($urandom % 400 == 0);
            alloc_valid = ($urandom % 4) != 0;
            alloc_dest_addr = DA'($urandom);
            alloc_ins_type = IT'($urandom);
            if ($urandom % 120 == 0) alloc_exception = EX'(1 + $urandom % 15);
            for (int p = 0; p < NW; p++) begin
                if ($urandom % 2 == 0) continue;
                set_wb(p,
                       (rq.size() > 0 && $urandom % 8 != 0) ?
                           rq[$urandom_range(rq.size() - 1)].id :
                           int'($urandom % DEPTH),
                       $urandom,
                       ($urandom % 80 == 0) ? int'(1 + $urandom % 15) : 0);
            end
            tick();
        end
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
